dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_bank.sv | 46 ++++
 rtl/dmem_responder.sv | 126 ++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_responder block: FSM encoding,
// byte-lane geometry, default base address and address-to-word-index helper.
package dmem_pkg;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_WAIT   = 2'd1;
    localparam logic [1:0] ENC_ACCESS = 2'd2;
    localparam logic [1:0] ENC_RESP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_WAIT   = ENC_WAIT,
        ST_ACCESS = ENC_ACCESS,
        ST_RESP   = ENC_RESP
    } state_e;

    localparam int MASK_W = 8;
    localparam int LANES  = MASK_W;
    localparam int LANE_W = 8;

    localparam logic [63:0] DEF_BASE_ADDR = 64'h8000_0000;

    // Word index relative to the base; wraps for addresses below the base,
    // so callers must also compare the address against the base.
    function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                                input logic [63:0] base);
        logic [63:0] w_off;
        w_off = addr - base;
        return w_off >> 3;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port doubleword array with per-byte write enables and a registered
// read port; the read register can also be cleared for non-read responses.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic                  i_clr,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [MASK_W-1:0]     i_wmask,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (i_wmask[b]) begin
                    r_mem[i_idx][b*LANE_W +: LANE_W] <= i_wdata[b*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end else if (i_clr) begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: single outstanding aligned doubleword request,
// fixed programmable latency, byte-masked writes and range error reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          XLEN       = 64,
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [63:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          LATENCY    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    input  logic [MASK_W-1:0] i_req_wmask,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_err
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (XLEN != 64) begin : g_bad_xlen
        $error("dmem_responder: XLEN must be 64");
    end

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_e            r_state;
    logic [3:0]        r_cnt;
    logic              r_wen;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic              r_err;

    logic [63:0]       w_idx_full;
    logic              w_in_range;
    logic              w_access;
    logic              w_we;
    logic              w_re;
    logic              w_clr;
    logic              w_accept;

    assign w_accept    = (r_state == ST_IDLE) && i_req_valid;
    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_err   = r_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_cnt   <= LAT_M1;
                        r_state <= (LATENCY == 1) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: r_state <= ST_RESP;
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request fields are captured only on accept, so req_* is ignored while busy.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_wen   <= i_req_wen;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_wmask <= i_req_wmask;
        end
    end

    assign w_idx_full = addr_to_idx(r_addr, BASE_ADDR);
    assign w_in_range = (r_addr >= BASE_ADDR) && ((w_idx_full >> DEPTH_LOG2) == 64'd0);

    // Reset during ACCESS aborts the request, including a pending write.
    assign w_access = (r_state == ST_ACCESS) && i_rst_n;
    assign w_we     = w_access && r_wen && w_in_range;
    assign w_re     = w_access && !r_wen && w_in_range;
    assign w_clr    = w_access && !w_re;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == ST_ACCESS) begin
            r_err <= !w_in_range;
        end
    end

    dmem_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (XLEN)
    ) u_bank (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_clr   (w_clr),
        .i_idx   (w_idx_full[DEPTH_LOG2-1:0]),
        .i_wdata (r_wdata),
        .i_wmask (r_wmask),
        .o_rdata (o_rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 4, 1) driven with a
// vector table, hand-written corner sequences and random traffic vs a model.
module tb_dmem_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          NW   = 256;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        int          hold;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int lat_tab [3] = '{2, 4, 1};

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wen   [3];
    logic [63:0] req_addr  [3];
    logic [63:0] req_wdata [3];
    logic [7:0]  req_wmask [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [63:0] rsp_rdata [3];
    logic        rsp_err   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .XLEN       (64),
            .DEPTH_LOG2 (8),
            .BASE_ADDR  (BASE),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 4 : 1))
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n[g]),
            .i_req_valid (req_valid[g]),
            .o_req_ready (req_ready[g]),
            .i_req_wen   (req_wen[g]),
            .i_req_addr  (req_addr[g]),
            .i_req_wdata (req_wdata[g]),
            .i_req_wmask (req_wmask[g]),
            .o_rsp_valid (rsp_valid[g]),
            .i_rsp_ready (rsp_ready[g]),
            .o_rsp_rdata (rsp_rdata[g]),
            .o_rsp_err   (rsp_err[g])
        );
    end

    int total = 0;
    int bad   = 0;

    // Reference memory: value and per-byte "known" flags, keyed by instance/word.
    logic [63:0] mval [int];
    logic [7:0]  mkn  [int];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model(input int d, input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask,
                         output logic [63:0] erd, output logic [7:0] ekn, output logic eerr);
        int          key;
        logic [63:0] v;
        logic [7:0]  k;
        if (addr < BASE || addr >= BASE + 64'(NW * 8)) begin
            erd = '0; ekn = 8'hFF; eerr = 1'b1;
        end else begin
            key  = d * 1024 + int'((addr - BASE) / 8);
            eerr = 1'b0;
            if (wen) begin
                v = mval.exists(key) ? mval[key] : 64'd0;
                k = mkn.exists(key) ? mkn[key] : 8'd0;
                for (int b = 0; b < 8; b++) begin
                    if (mask[b]) begin
                        v[8*b +: 8] = wdata[8*b +: 8];
                        k[b] = 1'b1;
                    end
                end
                mval[key] = v;
                mkn[key]  = k;
                erd = '0; ekn = 8'hFF;
            end else if (mval.exists(key)) begin
                erd = mval[key]; ekn = mkn[key];
            end else begin
                erd = '0; ekn = 8'h00;
            end
        end
    endtask

    // One complete transaction from IDLE; called at a negedge, returns at a negedge.
    task automatic txn(input int d, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] mask, input int hold,
                       input logic [63:0] erd, input logic [7:0] ekn, input logic eerr);
        int          k;
        logic [63:0] km;
        logic [63:0] rd0;
        chk($sformatf("d%0d_ready_idle", d), 64'(req_ready[d]), 64'd1);
        req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr;
        req_wdata[d] = wdata; req_wmask[d] = mask;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0; req_wen[d] = ~wen;
        req_addr[d] = {$urandom, $urandom}; req_wdata[d] = {$urandom, $urandom};
        req_wmask[d] = 8'($urandom);
        k = 0;
        while (!rsp_valid[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("d%0d_latency", d), 64'(k), 64'(lat_tab[d]));
        for (int b = 0; b < 8; b++) km[8*b +: 8] = {8{ekn[b]}};
        rd0 = rsp_rdata[d];
        if (ekn != 8'h00) chk($sformatf("d%0d_rdata", d), rd0 & km, erd & km);
        chk($sformatf("d%0d_err", d), 64'(rsp_err[d]), 64'(eerr));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk($sformatf("d%0d_hold_valid", d), 64'(rsp_valid[d]), 64'd1);
            chk($sformatf("d%0d_hold_rdata", d), rsp_rdata[d], rd0);
            chk($sformatf("d%0d_hold_ready", d), 64'(req_ready[d]), 64'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk($sformatf("d%0d_valid_clr", d), 64'(rsp_valid[d]), 64'd0);
        chk($sformatf("d%0d_ready_back", d), 64'(req_ready[d]), 64'd1);
    endtask

    task automatic model_txn(input int d, input logic wen, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [7:0] mask, input int hold);
        logic [63:0] erd;
        logic [7:0]  ekn;
        logic        eerr;
        model(d, wen, addr, wdata, mask, erd, ekn, eerr);
        txn(d, wen, addr, wdata, mask, hold, erd, ekn, eerr);
    endtask

    // Accept a write, then pulse reset one cycle later; no response may follow.
    task automatic abort_write(input int d, input logic [63:0] addr, input logic [63:0] wdata);
        req_valid[d] = 1'b1; req_wen[d] = 1'b1; req_addr[d] = addr;
        req_wdata[d] = wdata; req_wmask[d] = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        rst_n[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("d%0d_abort_valid", d), 64'(rsp_valid[d]), 64'd0);
        rst_n[d] = 1'b1;
        for (int c = 0; c < lat_tab[d] + 3; c++) begin
            @(negedge clk);
            chk($sformatf("d%0d_abort_quiet", d), 64'(rsp_valid[d]), 64'd0);
        end
        chk($sformatf("d%0d_abort_ready", d), 64'(req_ready[d]), 64'd1);
    endtask

    vec_t tbl [14];

    initial begin
        logic [63:0] erd, a, wd;
        logic [7:0]  ekn;
        logic        eerr;
        int          p, j, r;

        tbl[0]  = '{1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 0, 64'h0, 1'b0};
        tbl[1]  = '{1'b0, 64'h8000_0013, 64'h0, 8'h00, 0, 64'h1122334455667788, 1'b0};
        tbl[2]  = '{1'b1, 64'h8000_0010, 64'h00000000AABB0000, 8'h0C, 0, 64'h0, 1'b0};
        tbl[3]  = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 5, 64'h11223344AABB7788, 1'b0};
        tbl[4]  = '{1'b1, 64'h8000_07F8, 64'h0123456789ABCDEF, 8'hFF, 0, 64'h0, 1'b0};
        tbl[5]  = '{1'b1, 64'h8000_0000, 64'hCAFEF00DDEADBEEF, 8'hFF, 0, 64'h0, 1'b0};
        tbl[6]  = '{1'b1, 64'h7FFF_FFF8, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 64'h0, 1'b1};
        tbl[7]  = '{1'b0, 64'h8000_07F8, 64'h0, 8'h00, 0, 64'h0123456789ABCDEF, 1'b0};
        tbl[8]  = '{1'b1, 64'h8000_0800, 64'h5555555555555555, 8'hFF, 0, 64'h0, 1'b1};
        tbl[9]  = '{1'b0, 64'h8000_0000, 64'h0, 8'h00, 0, 64'hCAFEF00DDEADBEEF, 1'b0};
        tbl[10] = '{1'b0, 64'h8000_0800, 64'h0, 8'h00, 1, 64'h0, 1'b1};
        tbl[11] = '{1'b1, 64'h8000_0010, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, 64'h0, 1'b0};
        tbl[12] = '{1'b0, 64'h8000_0017, 64'h0, 8'h00, 0, 64'h11223344AABB7788, 1'b0};
        tbl[13] = '{1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 2, 64'h0, 1'b1};

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_wen[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; req_wmask[d] = '0; rsp_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_rst_valid", d), 64'(rsp_valid[d]), 64'd0);
            chk($sformatf("d%0d_rst_rdata", d), rsp_rdata[d], 64'd0);
            chk($sformatf("d%0d_rst_err", d), 64'(rsp_err[d]), 64'd0);
            rst_n[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_post_rst_ready", d), 64'(req_ready[d]), 64'd1);
            chk($sformatf("d%0d_post_rst_valid", d), 64'(rsp_valid[d]), 64'd0);
        end

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 14; i++) begin
                model(d, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].mask, erd, ekn, eerr);
                txn(d, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].mask, tbl[i].hold,
                    tbl[i].exp_rdata, 8'hFF, tbl[i].exp_err);
            end
        end

        // Back-to-back reads with valid/ready held high: period is LATENCY
        // cycles to response, one handshake edge, then one accept edge.
        for (int d = 0; d < 3; d++) begin
            model(d, 1'b0, 64'h8000_0010, 64'h0, 8'h00, erd, ekn, eerr);
            p = lat_tab[d] + 2;
            req_wen[d] = 1'b0; req_addr[d] = 64'h8000_0010; rsp_ready[d] = 1'b1;
            req_valid[d] = 1'b1;
            for (int k = 0; k < 3 * p; k++) begin
                j = k % p;
                chk($sformatf("d%0d_b2b_ready", d), 64'(req_ready[d]), 64'(j == 0));
                chk($sformatf("d%0d_b2b_valid", d), 64'(rsp_valid[d]), 64'(j == lat_tab[d] + 1));
                if (j == lat_tab[d] + 1) chk($sformatf("d%0d_b2b_rdata", d), rsp_rdata[d], erd);
                @(negedge clk);
            end
            req_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
        end

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      a = BASE - 64'(8 * $urandom_range(1, 4));
                else if (r == 1) a = BASE + 64'(NW * 8) + 64'(8 * $urandom_range(0, 3));
                else if (r == 2) a = BASE + 64'((NW - 1) * 8) + 64'($urandom_range(0, 7));
                else             a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
                wd = {$urandom, $urandom};
                model_txn(d, 1'($urandom), a, wd, 8'($urandom), $urandom_range(0, 3));
            end
        end

        model_txn(1, 1'b1, 64'h8000_0020, 64'hA5A5_0000_1234_5678, 8'hFF, 0);
        abort_write(1, 64'h8000_0020, 64'h0BAD_0BAD_0BAD_0BAD);
        model_txn(1, 1'b0, 64'h8000_0020, 64'h0, 8'h00, 0);

        abort_write(2, 64'h8000_0030, 64'h0BAD_0BAD_0BAD_0BAD);
        model_txn(2, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 0);
        model_txn(2, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
